// File: rtl/fg_sequencer.sv
// Function-generator sequencer: phase-accumulator playback of an 8-point waveform,
// with a shadow program register set that is swapped in at the next period boundary.
module fg_sequencer #(
  parameter int ACC_W = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fg_en,
  input  logic         program_ready,
  input  logic [175:0] prog_bytes,
  output logic [11:0]  sample,
  output logic         sample_valid,
  output logic         period_start,
  output logic [11:0]  ps_setpoint,
  output logic [1:0]   range,
  output logic         running,
  output logic         loaded
);

  typedef enum logic [1:0] {IDLE, RUN, SWAP_PENDING} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [23:0]      act_freq_q, act_freq_d, sh_freq_q, sh_freq_d;
  logic [7:0][11:0] act_wf_q, act_wf_d, sh_wf_q, sh_wf_d;
  logic [1:0]       act_range_q, act_range_d, sh_range_q, sh_range_d;
  logic [11:0]      sample_q, sample_d;
  logic [11:0]      ps_setpoint_q, ps_setpoint_d;
  logic             sample_valid_q, sample_valid_d;
  logic             period_start_q, period_start_d;
  logic             running_q, running_d;
  logic             loaded_q, loaded_d;

  logic [11:0]      dec_ps;
  logic [23:0]      dec_freq;
  logic [7:0][11:0] dec_wf;
  logic [1:0]       dec_range;
  logic             unused_prog_bits;

  always_comb begin
    dec_ps    = {prog_bytes[3:0], prog_bytes[15:8]};
    dec_freq  = {prog_bytes[23:16], prog_bytes[31:24], prog_bytes[39:32]};
    dec_range = prog_bytes[169:168];
    for (int n = 0; n < 8; n++) begin
      dec_wf[n] = {prog_bytes[8*(5+2*n) +: 4], prog_bytes[8*(6+2*n) +: 8]};
    end
  end

  // High nibbles of the packed 12-bit fields carry no information.
  assign unused_prog_bits = ^{prog_bytes[7:4], prog_bytes[47:44], prog_bytes[63:60],
                              prog_bytes[79:76], prog_bytes[95:92], prog_bytes[111:108],
                              prog_bytes[127:124], prog_bytes[143:140], prog_bytes[159:156],
                              prog_bytes[175:170]};

  logic [ACC_W:0] acc_sum;
  logic           carry;
  logic [2:0]     idx_cur, idx_nxt;

  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(act_freq_q);
  assign carry   = acc_sum[ACC_W];
  assign idx_cur = acc_q[ACC_W-1 -: 3];
  assign idx_nxt = acc_sum[ACC_W-1 -: 3];

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    act_freq_d     = act_freq_q;
    act_wf_d       = act_wf_q;
    act_range_d    = act_range_q;
    sh_freq_d      = sh_freq_q;
    sh_wf_d        = sh_wf_q;
    sh_range_d     = sh_range_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    period_start_d = 1'b0;
    ps_setpoint_d  = ps_setpoint_q;
    loaded_d       = loaded_q;

    if (program_ready) begin
      ps_setpoint_d = dec_ps;
      loaded_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        acc_d    = '0;
        sample_d = '0;
        if (program_ready) begin
          act_freq_d  = dec_freq;
          act_wf_d    = dec_wf;
          act_range_d = dec_range;
          sh_freq_d   = dec_freq;
          sh_wf_d     = dec_wf;
          sh_range_d  = dec_range;
        end
        if (fg_en && loaded_q) begin
          state_d        = RUN;
          sample_d       = act_wf_d[0];
          sample_valid_d = 1'b1;
          period_start_d = 1'b1;
        end
      end

      RUN, SWAP_PENDING: begin
        if (!fg_en) begin
          // Stopping never loses a pending program: it becomes the active one.
          state_d  = IDLE;
          acc_d    = '0;
          sample_d = '0;
          if (state_q == SWAP_PENDING) begin
            act_freq_d  = sh_freq_q;
            act_wf_d    = sh_wf_q;
            act_range_d = sh_range_q;
          end
          if (program_ready) begin
            act_freq_d  = dec_freq;
            act_wf_d    = dec_wf;
            act_range_d = dec_range;
            sh_freq_d   = dec_freq;
            sh_wf_d     = dec_wf;
            sh_range_d  = dec_range;
          end
        end else if ((state_q == SWAP_PENDING) && carry) begin
          act_freq_d     = sh_freq_q;
          act_wf_d       = sh_wf_q;
          act_range_d    = sh_range_q;
          acc_d          = '0;
          sample_d       = sh_wf_q[0];
          sample_valid_d = 1'b1;
          period_start_d = 1'b1;
          if (program_ready) begin
            sh_freq_d  = dec_freq;
            sh_wf_d    = dec_wf;
            sh_range_d = dec_range;
          end else begin
            state_d = RUN;
          end
        end else begin
          acc_d = acc_sum[ACC_W-1:0];
          if (idx_nxt != idx_cur) begin
            sample_d       = act_wf_q[idx_nxt];
            sample_valid_d = 1'b1;
          end
          period_start_d = carry;
          if (program_ready) begin
            sh_freq_d  = dec_freq;
            sh_wf_d    = dec_wf;
            sh_range_d = dec_range;
            state_d    = SWAP_PENDING;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      act_freq_q     <= '0;
      act_wf_q       <= '0;
      act_range_q    <= '0;
      sh_freq_q      <= '0;
      sh_wf_q        <= '0;
      sh_range_q     <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      period_start_q <= 1'b0;
      ps_setpoint_q  <= '0;
      running_q      <= 1'b0;
      loaded_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      act_freq_q     <= act_freq_d;
      act_wf_q       <= act_wf_d;
      act_range_q    <= act_range_d;
      sh_freq_q      <= sh_freq_d;
      sh_wf_q        <= sh_wf_d;
      sh_range_q     <= sh_range_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      period_start_q <= period_start_d;
      ps_setpoint_q  <= ps_setpoint_d;
      running_q      <= running_d;
      loaded_q       <= loaded_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign period_start = period_start_q;
  assign ps_setpoint  = ps_setpoint_q;
  assign range        = act_range_q;
  assign running      = running_q;
  assign loaded       = loaded_q;

endmodule
